// File: rtl/ram_burst_pkg.sv
// ---------------------------------------------------------------------------
// ram_burst_pkg
// Shared definitions for the RAM burst controller: default widths, the
// maximum burst length, the read/write opcode values (same polarity as the
// RAM RW pin) and the controller state encoding.
// ---------------------------------------------------------------------------
package ram_burst_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 5;

    // Longest burst in words; larger requested lengths are clamped to this.
    localparam int MAX_BURST  = 16;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } burst_state_e;

endpackage

// File: rtl/ram_burst_counter.sv
// ---------------------------------------------------------------------------
// ram_burst_counter
// Loadable word-address incrementer paired with a remaining-word
// down-counter. The address wraps modulo 2^ADDR_W without any error.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   load_i   : load addr_i / len_i (takes priority over step_i)
//   addr_i   : base address to load
//   len_i    : word count to load (already clamped by the caller)
//   step_i   : one word transferred; advance address, decrement count
//   addr_o   : current word address
//   last_o   : exactly one word remaining
//   empty_o  : no words remaining
// ---------------------------------------------------------------------------
module ram_burst_counter
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q,  rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = addr_i;
            rem_d  = len_i;
        end else if (step_i && (rem_q != '0)) begin
            // Natural overflow of the adder gives the modulo-2^ADDR_W wrap.
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o  = addr_q;
    assign last_o  = (rem_q == LEN_W'(1));
    assign empty_o = (rem_q == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl
// Burst sequencer in front of a single-port RAM with combinational read data.
// Accepts one read or write burst of 0..16 words and moves one word per
// clock across valid/ready streams, driving the RAM Enable/RW/Address/In
// pins and registering the RAM Out bus into RData.
//
// Build option: define RAM_BURST_CSUM_EN to add the Csum output, the XOR of
// every word transferred in the current burst (cleared on command accept).
//
// Ports:
//   Clock, Reset_n            : clock (rising edge), async active-low reset
//   Cmd_Valid/Ready/Op/Addr/Len : burst command handshake (Op 0=write, 1=read)
//   WData/WData_Valid/Ready   : write stream into the controller
//   RData/RData_Valid/Ready   : registered read stream out of the controller
//   Done                      : one-cycle pulse at burst completion
//   Busy                      : burst in progress
//   Ram_Enable/RW/Address/In  : RAM control and write data (RW rests at 1)
//   Ram_Out                   : RAM read data
//   Csum                      : (RAM_BURST_CSUM_EN only) burst XOR checksum
// ---------------------------------------------------------------------------
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic              Cmd_Op,
    input  logic [ADDR_W-1:0] Cmd_Addr,
    input  logic [LEN_W-1:0]  Cmd_Len,
    input  logic [DATA_W-1:0] WData,
    input  logic              WData_Valid,
    output logic              WData_Ready,
    output logic [DATA_W-1:0] RData,
    output logic              RData_Valid,
    input  logic              RData_Ready,
    output logic              Done,
    output logic              Busy,
    output logic              Ram_Enable,
    output logic              Ram_RW,
    output logic [ADDR_W-1:0] Ram_Address,
    output logic [DATA_W-1:0] Ram_In,
    input  logic [DATA_W-1:0] Ram_Out
`ifdef RAM_BURST_CSUM_EN
    ,
    output logic [DATA_W-1:0] Csum
`endif
);

    burst_state_e      state_q;
    logic              busy_q;
    logic              done_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] cur_addr;
    logic              last_word;
    logic              no_words;
    logic [LEN_W-1:0]  len_clamped;
    logic              accept;
    logic              wr_fire;
    logic              rd_issue;
    logic              rd_drain;

    always_comb begin
        len_clamped = Cmd_Len;
        if (Cmd_Len > LEN_W'(MAX_BURST)) begin
            len_clamped = LEN_W'(MAX_BURST);
        end
    end

    assign accept  = (state_q == IDLE) && Cmd_Valid;
    assign wr_fire = (state_q == WRITE) && WData_Valid;
    // A read may issue whenever the output register is free or being drained
    // this cycle, which sustains one word per clock.
    assign rd_issue = (state_q == READ) && !no_words && (!rvalid_q || RData_Ready);
    // All words issued: finish once the final word leaves the output register.
    assign rd_drain = (state_q == READ) && no_words && (!rvalid_q || RData_Ready);

    ram_burst_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_counter (
        .clk_i   (Clock),
        .rst_ni  (Reset_n),
        .load_i  (accept),
        .addr_i  (Cmd_Addr),
        .len_i   (len_clamped),
        .step_i  (wr_fire || rd_issue),
        .addr_o  (cur_addr),
        .last_o  (last_word),
        .empty_o (no_words)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (rd_issue) begin
                rdata_q  <= Ram_Out;
                rvalid_q <= 1'b1;
            end else if (RData_Ready) begin
                rvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (Cmd_Valid) begin
                        if (len_clamped == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= (Cmd_Op == OP_READ) ? READ : WRITE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire && last_word) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_drain) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_BURST_CSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (wr_fire) begin
            csum_q <= csum_q ^ WData;
        end else if (rd_issue) begin
            csum_q <= csum_q ^ Ram_Out;
        end
    end

    assign Csum = csum_q;
`endif

    assign Cmd_Ready   = (state_q == IDLE);
    assign WData_Ready = (state_q == WRITE);
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign RData       = rdata_q;
    assign RData_Valid = rvalid_q;

    // RW is held at read except during an actual write so the RAM never sees
    // a spurious write strobe.
    assign Ram_Enable  = wr_fire || rd_issue;
    assign Ram_RW      = !wr_fire;
    assign Ram_Address = cur_addr;
    assign Ram_In      = wr_fire ? WData : '0;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_ctrl
// Directed and randomized bench for ram_burst_ctrl. A behavioural RAM is
// attached to the RAM pins; a separate reference memory holds what the RAM
// should contain, from which expected write logs and read streams are built.
// ---------------------------------------------------------------------------
module tb_ram_burst_ctrl;

    logic        clk;
    logic        Reset_n;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic        Cmd_Op;
    logic [15:0] Cmd_Addr;
    logic [4:0]  Cmd_Len;
    logic [31:0] WData;
    logic        WData_Valid;
    logic        WData_Ready;
    logic [31:0] RData;
    logic        RData_Valid;
    logic        RData_Ready;
    logic        Done;
    logic        Busy;
    logic        Ram_Enable;
    logic        Ram_RW;
    logic [15:0] Ram_Address;
    logic [31:0] Ram_In;
    logic [31:0] Ram_Out;
`ifdef RAM_BURST_CSUM_EN
    logic [31:0] Csum;
`endif

    ram_burst_ctrl dut (
        .Clock       (clk),
        .Reset_n     (Reset_n),
        .Cmd_Valid   (Cmd_Valid),
        .Cmd_Ready   (Cmd_Ready),
        .Cmd_Op      (Cmd_Op),
        .Cmd_Addr    (Cmd_Addr),
        .Cmd_Len     (Cmd_Len),
        .WData       (WData),
        .WData_Valid (WData_Valid),
        .WData_Ready (WData_Ready),
        .RData       (RData),
        .RData_Valid (RData_Valid),
        .RData_Ready (RData_Ready),
        .Done        (Done),
        .Busy        (Busy),
        .Ram_Enable  (Ram_Enable),
        .Ram_RW      (Ram_RW),
        .Ram_Address (Ram_Address),
        .Ram_In      (Ram_In),
        .Ram_Out     (Ram_Out)
`ifdef RAM_BURST_CSUM_EN
        ,
        .Csum        (Csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the rising edge.
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    assign Ram_Out = mem[Ram_Address];

    always @(posedge clk) begin
        if (Ram_Enable && !Ram_RW) mem[Ram_Address] <= Ram_In;
    end

    // Transfer monitor, sampled mid-cycle after the drivers have settled.
    int          en_count;
    int          done_count;
    logic [47:0] wr_log[$];
    logic [31:0] rd_log[$];

    always @(negedge clk) begin
        #2;
        if (Ram_Enable) en_count++;
        if (Ram_Enable && !Ram_RW) wr_log.push_back({Ram_Address, Ram_In});
        if (RData_Valid && RData_Ready) rd_log.push_back(RData);
        if (Done) done_count++;
    end

    int          errors;
    int          checks;
    logic [31:0] wq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_wq(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    // Write burst; data comes from wq. Junk commands are presented while busy.
    task automatic do_write(input logic [15:0] addr, input logic [4:0] len,
                            input int stall_pct, output int done_cyc);
        int          n;
        int          idx;
        int          cyc;
        bit          seen;
        logic [31:0] cs;
        n  = (len > 5'd16) ? 16 : int'(len);
        cs = '0;
        for (int i = 0; i < n; i++) cs ^= wq[i];
        wr_log.delete();
        en_count = 0;
        @(negedge clk);
        Cmd_Valid = 1'b1; Cmd_Op = 1'b0; Cmd_Addr = addr; Cmd_Len = len;
        #1 check("wr_cmd_ready", Cmd_Ready, 1);
        @(negedge clk);
        idx = 0; cyc = 0; seen = 0; done_cyc = -1;
        while (!seen && cyc < 400) begin
            Cmd_Valid = 1'b1; Cmd_Op = 1'($urandom); Cmd_Addr = 16'($urandom); Cmd_Len = 5'($urandom);
            if (idx < n && $urandom_range(99) >= stall_pct) begin
                WData_Valid = 1'b1; WData = wq[idx];
            end else begin
                WData_Valid = 1'b0; WData = $urandom;
            end
            #1;
            if (Done) begin
                seen = 1; done_cyc = cyc;
                check("wr_done_busy", Busy, 0);
`ifdef RAM_BURST_CSUM_EN
                check("wr_csum", Csum, cs);
`endif
            end else begin
                check("wr_busy_ready", {Busy, Cmd_Ready, WData_Ready}, 3'b101);
                if (WData_Valid && WData_Ready) idx++;
            end
            cyc++;
            @(negedge clk);
        end
        Cmd_Valid = 1'b0; WData_Valid = 1'b0;
        #1;
        check("wr_done_seen", seen, 1);
        check("wr_idle_after", {Done, Cmd_Ready, Busy}, 3'b010);
        check("wr_word_count", wr_log.size(), n);
        check("wr_enable_count", en_count, n);
        for (int i = 0; i < n && i < wr_log.size(); i++)
            check("wr_addr_data", wr_log[i], {16'(addr + i), wq[i]});
        for (int i = 0; i < n; i++) begin
            ref_mem[16'(addr + i)] = wq[i];
            check("mem_dump", mem[16'(addr + i)], wq[i]);
        end
    endtask

    // Read burst; expected stream taken from the reference memory.
    task automatic do_read(input logic [15:0] addr, input logic [4:0] len,
                           input int stall_pct, input bit hold3, output int done_cyc);
        int          n;
        int          cyc;
        bit          seen;
        logic [31:0] exp_q[$];
        logic [31:0] cs;
        n  = (len > 5'd16) ? 16 : int'(len);
        cs = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ref_mem[16'(addr + i)]);
            cs ^= ref_mem[16'(addr + i)];
        end
        rd_log.delete();
        en_count = 0;
        @(negedge clk);
        Cmd_Valid = 1'b1; Cmd_Op = 1'b1; Cmd_Addr = addr; Cmd_Len = len; RData_Ready = 1'b0;
        #1 check("rd_cmd_ready", Cmd_Ready, 1);
        @(negedge clk);
        cyc = 0; seen = 0; done_cyc = -1;
        while (!seen && cyc < 400) begin
            Cmd_Valid = 1'b1; Cmd_Op = 1'($urandom); Cmd_Addr = 16'($urandom); Cmd_Len = 5'($urandom);
            if (hold3) RData_Ready = !(cyc >= 1 && cyc <= 3);
            else       RData_Ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (hold3 && cyc >= 1 && cyc <= 3) begin
                check("hold_rdata", {RData_Valid, RData}, {1'b1, exp_q[0]});
                check("hold_no_issue", Ram_Enable, 0);
            end
            if (Done) begin
                seen = 1; done_cyc = cyc;
                check("rd_done_busy", Busy, 0);
`ifdef RAM_BURST_CSUM_EN
                check("rd_csum", Csum, cs);
`endif
            end else begin
                check("rd_busy_ready", {Busy, Cmd_Ready}, 2'b10);
            end
            cyc++;
            @(negedge clk);
        end
        Cmd_Valid = 1'b0; RData_Ready = 1'b0;
        #1;
        check("rd_done_seen", seen, 1);
        check("rd_idle_after", {Done, Cmd_Ready, Busy, RData_Valid}, 4'b0100);
        check("rd_word_count", rd_log.size(), n);
        check("rd_enable_count", en_count, n);
        for (int i = 0; i < n && i < rd_log.size(); i++)
            check("rd_data", rd_log[i], exp_q[i]);
    endtask

    initial begin
        int          dc;
        int          dcount0;
        logic [15:0] a;
        logic [4:0]  l;
        errors = 0; checks = 0; en_count = 0; done_count = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        Reset_n = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = 1'b0; Cmd_Addr = '0; Cmd_Len = '0;
        WData = '0; WData_Valid = 1'b0; RData_Ready = 1'b0;

        // Reset state
        #1;
        check("rst_ram_pins", {Ram_Enable, Ram_RW, Ram_Address, Ram_In}, {1'b0, 1'b1, 16'h0, 32'h0});
        check("rst_rdata", {RData_Valid, RData}, 33'h0);
        check("rst_ctrl", {Done, Busy, Cmd_Ready, WData_Ready}, 4'b0010);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;

        // Test 1: four-word write from address 0, no stalls
        wq = '{32'hAAAAAAAA, 32'hBBBBAAAA, 32'hCCCC00AA, 32'hDDDD00BB};
        do_write(16'h0000, 5'd4, 0, dc);
        check("t1_done_cycle", dc, 4);

        // Test 2: read back three words at full rate
        do_read(16'h0001, 5'd3, 0, 1'b0, dc);
        check("t2_done_cycle", dc, 4);
        check("t2_first_word", rd_log.size() > 0 ? rd_log[0] : 32'hx, 32'hBBBBAAAA);

        // Test 3: downstream stalls for three cycles after the first word
        do_read(16'h0001, 5'd3, 0, 1'b1, dc);

        // Test 4: address wrap
        fill_wq(4);
        do_write(16'hFFFE, 5'd4, 0, dc);
        check("t4_wrap_0000", mem[16'h0000], wq[2]);
        check("t4_wrap_0001", mem[16'h0001], wq[3]);

        // Test 5: zero length and clamped length
        wq.delete();
        do_write(16'h0100, 5'd0, 0, dc);
        check("t5_len0_wr_done", dc, 0);
        do_read(16'h0100, 5'd0, 0, 1'b0, dc);
        check("t5_len0_rd_done", dc, 0);
        fill_wq(16);
        do_write(16'h0200, 5'd31, 0, dc);
        check("t5_len31_done", dc, 16);
        do_read(16'h0200, 5'd31, 25, 1'b0, dc);

        // Randomized bursts with stalls on both streams, each read back
        for (int k = 0; k < 6; k++) begin
            a = ($urandom_range(2) == 0) ? 16'hFFF8 + 16'($urandom_range(7)) : 16'($urandom);
            l = 5'($urandom_range(20));
            fill_wq(16);
            do_write(a, l, 30, dc);
            do_read(a, l, 30, 1'b0, dc);
        end

        // Test 6: asynchronous reset in the middle of an eight-word write
        fill_wq(8);
        wr_log.delete();
        @(negedge clk);
        Cmd_Valid = 1'b1; Cmd_Op = 1'b0; Cmd_Addr = 16'h0300; Cmd_Len = 5'd8;
        @(negedge clk);
        Cmd_Valid = 1'b0;
        en_count = 0;
        for (int i = 0; i < 3; i++) begin
            WData_Valid = 1'b1; WData = wq[i];
            @(negedge clk);
        end
        WData_Valid = 1'b0;
        dcount0 = done_count;
        #3 Reset_n = 1'b0;
        WData_Valid = 1'b1; WData = wq[3];
        #1;
        check("t6_ram_pins", {Ram_Enable, Ram_RW, Ram_Address, Ram_In}, {1'b0, 1'b1, 16'h0, 32'h0});
        check("t6_rdata", {RData_Valid, RData}, 33'h0);
        check("t6_ctrl", {Done, Busy, Cmd_Ready, WData_Ready}, 4'b0010);
        repeat (2) @(negedge clk);
        WData_Valid = 1'b0;
        Reset_n = 1'b1;
        check("t6_no_done", done_count, dcount0);
        check("t6_enable_count", en_count, 3);
        check("t6_word_count", wr_log.size(), 3);
        for (int i = 0; i < 3; i++) ref_mem[16'h0300 + 16'(i)] = wq[i];
        fill_wq(2);
        do_write(16'h0300, 5'd2, 0, dc);
        check("t6_new_cmd_done", dc, 2);
        do_read(16'h0300, 5'd4, 0, 1'b0, dc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
